// File: rtl/seg_memory.sv
// rtl/seg_memory.sv - MIPS MEM stage: data memory, branch resolve, built-in MEM/WB latch
module seg_memory #(
    parameter int LEN        = 32,
    parameter int NB_ADDR    = 5,
    parameter int NB_CTRL_WB = 2,
    parameter int NB_CTRL_M  = 9,
    parameter int NB_DEPTH   = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [LEN-1:0]        i_ALU_result,
    input  logic [LEN-1:0]        i_write_data,
    input  logic [NB_ADDR-1:0]    i_write_register,
    input  logic                  i_ALU_zero,
    input  logic [LEN-1:0]        i_PC_branch,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
    input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
    input  logic [NB_DEPTH-1:0]   i_dbg_addr,
    output logic [LEN-1:0]        o_PC_branch,
    output logic                  o_pc_src,
    output logic [LEN-1:0]        o_rd_mem_forwarding,
    output logic [LEN-1:0]        o_read_data,
    output logic [LEN-1:0]        o_ALU_result,
    output logic [NB_ADDR-1:0]    o_write_register,
    output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
    output logic                  o_misaligned,
    output logic [LEN-1:0]        o_dbg_data
);

    localparam int DEPTH = 2 ** NB_DEPTH;

    logic [LEN-1:0] mem [DEPTH];

    logic                branch;
    logic                branch_ne;
    logic                mem_read;
    logic                mem_write;
    logic                load_unsigned;
    logic                is_word;
    logic                is_half;
    logic [NB_DEPTH-1:0] word_idx;
    logic [1:0]          lane;
    logic                misaligned;
    logic [LEN-1:0]      rd_word;
    logic [LEN-1:0]      wr_word;
    logic [7:0]          byte_val;
    logic [15:0]         half_val;
    logic [LEN-1:0]      load_val;
    logic                unused_bits;

    assign branch        = i_ctrl_mem_bus[8];
    assign branch_ne     = i_ctrl_mem_bus[7];
    assign mem_read      = i_ctrl_mem_bus[6];
    assign mem_write     = i_ctrl_mem_bus[5];
    assign load_unsigned = i_ctrl_mem_bus[4];
    // Size 1x is a word access; 10 and 11 behave identically.
    assign is_word       = i_ctrl_mem_bus[3];
    assign is_half       = ~i_ctrl_mem_bus[3] & i_ctrl_mem_bus[2];

    // Upper address bits are dropped so the address space wraps on the array size.
    assign word_idx = i_ALU_result[NB_DEPTH+1:2];
    assign lane     = i_ALU_result[1:0];

    assign unused_bits = ^{i_ALU_result[LEN-1:NB_DEPTH+2], i_ctrl_mem_bus[1:0]};

    assign misaligned = (mem_read | mem_write) &
                        ((is_half & lane[0]) | (is_word & (lane != 2'b00)));

    assign o_PC_branch         = i_PC_branch;
    assign o_pc_src            = (branch & i_ALU_zero) | (branch_ne & ~i_ALU_zero);
    assign o_rd_mem_forwarding = i_ALU_result;
    assign o_dbg_data          = mem[i_dbg_addr];

    assign rd_word  = mem[word_idx];
    assign byte_val = rd_word[{lane, 3'b000} +: 8];
    assign half_val = rd_word[{lane[1], 4'b0000} +: 16];

    // Lane extraction plus sign/zero extension of the pre-write word.
    always_comb begin
        load_val = '0;
        if (is_word) begin
            load_val = rd_word;
        end else if (is_half) begin
            load_val = load_unsigned ? {{(LEN-16){1'b0}}, half_val}
                                     : {{(LEN-16){half_val[15]}}, half_val};
        end else begin
            load_val = load_unsigned ? {{(LEN-8){1'b0}}, byte_val}
                                     : {{(LEN-8){byte_val[7]}}, byte_val};
        end
    end

    // Merge store data into the current word so unselected lanes keep their value.
    always_comb begin
        wr_word = rd_word;
        if (is_word) begin
            wr_word = i_write_data;
        end else if (is_half) begin
            wr_word[{lane[1], 4'b0000} +: 16] = i_write_data[15:0];
        end else begin
            wr_word[{lane, 3'b000} +: 8] = i_write_data[7:0];
        end
    end

    // Data array: cleared by reset, otherwise aligned stores commit on the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_write && !misaligned) begin
            mem[word_idx] <= wr_word;
        end
    end

    // MEM/WB latch; a misaligned access drops its load data and its register write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_read_data      <= '0;
            o_ALU_result     <= '0;
            o_write_register <= '0;
            o_ctrl_wb_bus    <= '0;
            o_misaligned     <= 1'b0;
        end else begin
            o_read_data      <= (mem_read && !misaligned) ? load_val : '0;
            o_ALU_result     <= i_ALU_result;
            o_write_register <= i_write_register;
            o_ctrl_wb_bus    <= i_ctrl_wb_bus;
            o_ctrl_wb_bus[1] <= i_ctrl_wb_bus[1] & ~misaligned;
            o_misaligned     <= misaligned;
        end
    end

endmodule
